// File: rtl/ff_exc_pkg.sv
// Shared types for the flip-flop excitation decoder: FSM state and JK excitation codes.
package ff_exc_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } exc_state_t;

  // {J,K} pairs, used when replaying decoded words onto JK banks.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/exc_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module exc_popcount #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [CW-1:0]    o_count
);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/ff_excitation_decoder.sv
// Recovers per-bit D/T/JK excitation between consecutive register samples,
// with a single registered output stage and saturating activity counters.
module ff_excitation_decoder
  import ff_exc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_exc,
  output logic [WIDTH-1:0] t_exc,
  output logic [WIDTH-1:0] j_exc,
  output logic [WIDTH-1:0] k_exc,
  output logic [CNT_W-1:0] trans_count,
  output logic [CNT_W-1:0] toggle_count
);

  localparam int unsigned PW = $clog2(WIDTH + 1);

  exc_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_d, r_t, r_j, r_k;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_trans, r_toggle;
  logic             w_ready, w_accept, w_emit;
  logic [WIDTH-1:0] w_t, w_j, w_k;
  logic [PW-1:0]    w_pop;
  logic [CNT_W:0]   w_tog_sum;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    if (r_state == PRIMED) w_ready = !r_out_valid || out_ready;
    w_accept = in_valid && w_ready;
    w_emit   = w_accept && (r_state == PRIMED);
    if (clear)         w_state_nxt = EMPTY;
    else if (w_accept) w_state_nxt = PRIMED;
  end

  // JK don't-cares resolved to 0: only the input that forces the change is asserted.
  assign w_t = r_prev ^ q_in;
  assign w_j = ~r_prev & q_in;
  assign w_k = r_prev & ~q_in;

  exc_popcount #(.WIDTH(WIDTH), .CW(PW)) u_pop (
    .i_bits  (w_t),
    .o_count (w_pop)
  );

  // One extra carry bit detects overflow so a partial add clamps to max.
  assign w_tog_sum = {1'b0, r_toggle} + (CNT_W+1)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_d         <= '0;
      r_t         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_trans     <= '0;
      r_toggle    <= '0;
    end else if (clear) begin
      r_prev      <= '0;
      r_out_valid <= 1'b0;
      r_trans     <= '0;
      r_toggle    <= '0;
    end else begin
      if (w_accept) r_prev <= q_in;
      if (w_emit) begin
        r_d         <= q_in;
        r_t         <= w_t;
        r_j         <= w_j;
        r_k         <= w_k;
        r_out_valid <= 1'b1;
        r_trans     <= (r_trans == '1) ? r_trans : r_trans + CNT_W'(1);
        r_toggle    <= w_tog_sum[CNT_W] ? '1 : w_tog_sum[CNT_W-1:0];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready     = w_ready;
  assign out_valid    = r_out_valid;
  assign d_exc        = r_d;
  assign t_exc        = r_t;
  assign j_exc        = r_j;
  assign k_exc        = r_k;
  assign trans_count  = r_trans;
  assign toggle_count = r_toggle;

endmodule

// File: tb/tb_ff_excitation_decoder.sv
// Randomised and directed checks of ff_excitation_decoder against a transition-table model.
module tb_ff_excitation_decoder;
  import ff_exc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] q_in = '0;
  logic       in_ready, out_valid;
  logic [7:0] d_exc, t_exc, j_exc, k_exc;
  logic [15:0] trans_count, toggle_count;
  logic       u4_in_ready, u4_out_valid;
  logic [7:0] u4_d, u4_t, u4_j, u4_k;
  logic [3:0] tc4, gc4;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit         m_primed, m_ov;
  logic [7:0] m_prev, m_d, m_t, m_j, m_k;
  int         m_trans, m_tog, m_trans4, m_tog4;
  logic       exp_ready, obs_ready;

  always #5 clk = ~clk;

  ff_excitation_decoder #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
    .d_exc(d_exc), .t_exc(t_exc), .j_exc(j_exc), .k_exc(k_exc),
    .trans_count(trans_count), .toggle_count(toggle_count)
  );

  ff_excitation_decoder #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(u4_in_ready),
    .q_in(q_in), .out_valid(u4_out_valid), .out_ready(out_ready),
    .d_exc(u4_d), .t_exc(u4_t), .j_exc(u4_j), .k_exc(u4_k),
    .trans_count(tc4), .toggle_count(gc4)
  );

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_primed = 0; m_ov = 0; m_prev = '0;
    m_d = '0; m_t = '0; m_j = '0; m_k = '0;
    m_trans = 0; m_tog = 0; m_trans4 = 0; m_tog4 = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] q, input logic r, input logic c);
    bit acc;
    int flips;
    logic [1:0] code;
    acc = v && exp_ready;
    if (c) begin
      m_primed = 0; m_ov = 0; m_prev = '0;
      m_trans = 0; m_tog = 0; m_trans4 = 0; m_tog4 = 0;
    end else if (acc && !m_primed) begin
      m_primed = 1; m_prev = q;
    end else if (acc) begin
      flips = 0;
      for (int b = 0; b < 8; b++) begin
        if (m_prev[b] == q[b]) code = JK_HOLD;
        else if (q[b])         code = JK_SET;
        else                   code = JK_RST;
        m_j[b] = code[1];
        m_k[b] = code[0];
        m_t[b] = (m_prev[b] != q[b]);
        if (m_prev[b] != q[b]) flips++;
      end
      m_d = q;
      m_ov = 1;
      m_trans  = sat(m_trans + 1, 65535);
      m_tog    = sat(m_tog + flips, 65535);
      m_trans4 = sat(m_trans4 + 1, 15);
      m_tog4   = sat(m_tog4 + flips, 15);
      m_prev = q;
    end else if (m_ov && r) begin
      m_ov = 0;
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic drive(input logic v, input logic [7:0] q, input logic r, input logic c);
    in_valid = v; q_in = q; out_ready = r; clear = c;
    #1;
    exp_ready = !m_primed || !m_ov || r;
    obs_ready = in_ready;
    @(posedge clk);
    model_step(v, q, r, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #12;
    n_tests++;
    if ({out_valid, d_exc, t_exc, j_exc, k_exc} !== 33'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=0", {out_valid, d_exc, t_exc, j_exc, k_exc});
    end
    n_tests++;
    if ({trans_count, toggle_count} !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters got=%h want=0", {trans_count, toggle_count});
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    drive(1, 8'h00, 1, 0);
    n_tests++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_sample ready=%b ov=%b want ready=1 ov=0", obs_ready, out_valid);
    end
    drive(1, 8'hFF, 1, 0);
    n_tests++;
    if ({out_valid, d_exc, t_exc, j_exc, k_exc} !== {1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00}) begin
      n_fail++; $display("FAIL word_00_FF got=%h want=%h", {out_valid, d_exc, t_exc, j_exc, k_exc},
                         {1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00});
    end
    drive(1, 8'hF0, 1, 0);
    n_tests++;
    if ({out_valid, d_exc, t_exc, j_exc, k_exc} !== {1'b1, 8'hF0, 8'h0F, 8'h00, 8'h0F}) begin
      n_fail++; $display("FAIL word_FF_F0 got=%h want=%h", {out_valid, d_exc, t_exc, j_exc, k_exc},
                         {1'b1, 8'hF0, 8'h0F, 8'h00, 8'h0F});
    end
    n_tests++;
    if (trans_count !== 16'd2 || toggle_count !== 16'd12) begin
      n_fail++; $display("FAIL directed_counts got=%0d/%0d want=2/12", trans_count, toggle_count);
    end
    drive(0, 8'h00, 1, 0);
    n_tests++;
    if (out_valid !== 1'b0 || d_exc !== 8'hF0) begin
      n_fail++; $display("FAIL drain_hold ov=%b d=%h want ov=0 d=f0", out_valid, d_exc);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] snap;
    drive(0, 8'h00, 1, 1);
    drive(1, 8'h3C, 1, 0);
    drive(1, 8'hC3, 0, 0);
    snap = {out_valid, d_exc, t_exc, j_exc, k_exc};
    for (int i = 0; i < 2; i++) begin
      drive(1, 8'h99, 0, 0);
      n_tests++;
      if (obs_ready !== 1'b0 || {out_valid, d_exc, t_exc, j_exc, k_exc} !== snap) begin
        n_fail++; $display("FAIL stall_hold ready=%b word=%h want ready=0 word=%h", obs_ready,
                           {out_valid, d_exc, t_exc, j_exc, k_exc}, snap);
      end
    end
    drive(1, 8'h99, 1, 0);
    n_tests++;
    if (obs_ready !== 1'b1 || {out_valid, d_exc, t_exc, j_exc, k_exc} !== {1'b1, m_d, m_t, m_j, m_k}) begin
      n_fail++; $display("FAIL drain_accept ready=%b word=%h want ready=1 word=%h", obs_ready,
                         {out_valid, d_exc, t_exc, j_exc, k_exc}, {1'b1, m_d, m_t, m_j, m_k});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      n_tests++;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, obs_ready, exp_ready);
      end
      n_tests++;
      if ({out_valid, d_exc, t_exc, j_exc, k_exc} !== {m_ov, m_d, m_t, m_j, m_k}) begin
        n_fail++; $display("FAIL rand_word cyc=%0d got=%h want=%h", i,
                           {out_valid, d_exc, t_exc, j_exc, k_exc}, {m_ov, m_d, m_t, m_j, m_k});
      end
      n_tests++;
      if (trans_count !== 16'(m_trans) || toggle_count !== 16'(m_tog) ||
          tc4 !== 4'(m_trans4) || gc4 !== 4'(m_tog4)) begin
        n_fail++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                           trans_count, toggle_count, tc4, gc4, m_trans, m_tog, m_trans4, m_tog4);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] trace [200];
    logic [7:0] qd, qt, qjk;
    for (int i = 0; i < 200; i++) trace[i] = 8'($urandom);
    trace[50] = trace[49];
    drive(0, 8'h00, 1, 1);
    qd = trace[0]; qt = trace[0]; qjk = trace[0];
    for (int i = 0; i < 200; i++) begin
      drive(1, trace[i], 1, 0);
      if (i > 0) begin
        qd = d_exc;
        qt = qt ^ t_exc;
        for (int b = 0; b < 8; b++) begin
          case ({j_exc[b], k_exc[b]})
            JK_SET:  qjk[b] = 1'b1;
            JK_RST:  qjk[b] = 1'b0;
            JK_TGL:  qjk[b] = ~qjk[b];
            default: qjk[b] = qjk[b];
          endcase
        end
        n_tests++;
        if (out_valid !== 1'b1 || qd !== trace[i] || qt !== trace[i] || qjk !== trace[i]) begin
          n_fail++; $display("FAIL round_trip step=%0d ov=%b d=%h t=%h jk=%h want=%h", i, out_valid,
                             qd, qt, qjk, trace[i]);
        end
      end
    end
    n_tests++;
    if (trans_count !== 16'd199 || toggle_count !== 16'(m_tog)) begin
      n_fail++; $display("FAIL trip_counts got=%0d/%0d want=199/%0d", trans_count, toggle_count, m_tog);
    end
  endtask

  task automatic test_saturation();
    drive(0, 8'h00, 1, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, (i % 2 == 1) ? 8'hFF : 8'h00, 1, 0);
      if (i == 2) begin
        n_tests++;
        if (gc4 !== 4'd15 || tc4 !== 4'd2) begin
          n_fail++; $display("FAIL partial_clamp got=%0d/%0d want=2/15", tc4, gc4);
        end
      end
    end
    n_tests++;
    if (tc4 !== 4'd15 || gc4 !== 4'd15) begin
      n_fail++; $display("FAIL sat_cnt4 got=%0d/%0d want=15/15", tc4, gc4);
    end
    n_tests++;
    if (trans_count !== 16'd19 || toggle_count !== 16'd152) begin
      n_fail++; $display("FAIL sat_cnt16 got=%0d/%0d want=19/152", trans_count, toggle_count);
    end
  endtask

  task automatic test_clear();
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'h5A, 1, 0);
    drive(1, 8'h55, 1, 1);
    n_tests++;
    if (out_valid !== 1'b0 || trans_count !== 16'd0 || toggle_count !== 16'd0) begin
      n_fail++; $display("FAIL clear_state ov=%b cnt=%0d/%0d want 0/0/0", out_valid, trans_count, toggle_count);
    end
    drive(1, 8'h0F, 1, 0);
    n_tests++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_prime ready=%b ov=%b want 1/0", obs_ready, out_valid);
    end
    drive(1, 8'hF0, 1, 0);
    n_tests++;
    if ({out_valid, t_exc, j_exc, k_exc} !== {1'b1, 8'hFF, 8'hF0, 8'h0F}) begin
      n_fail++; $display("FAIL clear_next got=%h want=%h", {out_valid, t_exc, j_exc, k_exc},
                         {1'b1, 8'hFF, 8'hF0, 8'h0F});
    end
    drive(1, 8'hF0, 1, 0);
    n_tests++;
    if ({out_valid, d_exc, t_exc, j_exc, k_exc} !== {1'b1, 8'hF0, 24'h0}) begin
      n_fail++; $display("FAIL repeat_sample got=%h want=%h", {out_valid, d_exc, t_exc, j_exc, k_exc},
                         {1'b1, 8'hF0, 24'h0});
    end
  endtask

  task automatic test_async_reset();
    drive(1, 8'h12, 0, 0);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_ov got=%b want=1", out_valid);
    end
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({out_valid, d_exc, t_exc, j_exc, k_exc, trans_count, toggle_count} !== 65'd0) begin
      n_fail++; $display("FAIL async_reset got=%h want=0",
                         {out_valid, d_exc, t_exc, j_exc, k_exc, trans_count, toggle_count});
    end
    model_reset();
    #2 rst_n = 1;
    @(posedge clk); #1;
    drive(1, 8'h81, 1, 0);
    n_tests++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_prime ready=%b ov=%b want 1/0", obs_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_round_trip();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
